// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern detector: state encodings and
// the legal range of the pattern length.
package seq_pkg;

  typedef enum logic [1:0] {
    FILL = 2'b00,
    SCAN = 2'b01,
    HIT  = 2'b10
  } state_t;

  localparam int PATTERN_W_MIN = 2;
  localparam int PATTERN_W_MAX = 8;

  function automatic bit legal_pattern_w(input int w);
    return (w >= PATTERN_W_MIN) && (w <= PATTERN_W_MAX);
  endfunction

endpackage

// File: rtl/seq_detect_fsm_sat_counter.sv
// Saturating match counter with a sticky saturation flag; a clear that
// coincides with an increment leaves the count at one.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= inc ? ONE : '0;
      sat   <= inc && (ONE == MAX);
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
      if (count == MAX - ONE) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: shifts accepted bits into a window, flags a
// registered match one cycle after the completing bit and counts matches.
module seq_detect_fsm
  import seq_pkg::*;
#(
  parameter int                   PATTERN_W = 3,
  parameter logic [PATTERN_W-1:0] PATTERN   = 3'b110,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In1,
  input  logic             In1_valid,
  input  logic             Clr,
  output logic             Out1,
  output logic [CNT_W-1:0] Match_cnt,
  output logic             Sat,
  output logic [1:0]       State
);

  localparam int                FILL_W = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PATTERN_W);

  if (!legal_pattern_w(PATTERN_W)) begin : g_illegal_width
    $error("seq_detect_fsm: PATTERN_W out of range");
  end

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] window_q, window_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 match;

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    match    = 1'b0;
    case (state_q)
      FILL, SCAN, HIT: begin
        if (In1_valid) begin
          window_d = {window_q[PATTERN_W-2:0], In1};
          fill_d   = (fill_q >= FULL) ? FULL : fill_q + FILL_W'(1);
          if ((fill_d == FULL) && (window_d == PATTERN)) begin
            match   = 1'b1;
            state_d = HIT;
            // Without overlap the next match must be built from fresh bits.
            if (!OVERLAP) begin
              fill_d = '0;
            end
          end else if (fill_d == FULL) begin
            state_d = SCAN;
          end else begin
            state_d = FILL;
          end
        end else if (state_q == HIT) begin
          state_d = OVERLAP ? SCAN : FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= FILL;
      window_q <= '0;
      fill_q   <= '0;
      Out1     <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      Out1     <= (state_d == HIT);
    end
  end

  assign State = state_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (match),
    .clr  (Clr),
    .count(Match_cnt),
    .sat  (Sat)
  );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Self-checking bench for seq_detect_fsm: four parameterisations share one
// stimulus stream and are checked against a windowed-history reference model.
module tb_seq_detect_fsm;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic In1 = 1'b0;
  logic In1_valid = 1'b0;
  logic Clr = 1'b0;

  logic       out0, out1, out2, out3;
  logic       sat0, sat1, sat2, sat3;
  logic [1:0] st0, st1, st2, st3;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int vectors = 0;
  int miscompares = 0;

  // Per-instance parameters mirrored for the reference model
  int pW[4]   = '{3, 3, 3, 3};
  int pPat[4] = '{6, 5, 5, 6};
  int pOv[4]  = '{1, 1, 0, 1};
  int pMax[4] = '{255, 255, 255, 3};

  int mLen[4];
  int mVal[4];
  int mSt[4];
  int mCnt[4];
  int mSat[4];

  typedef struct {
    bit v;
    bit d;
    bit c;
    int st;
    int o;
    int cnt;
  } vec_t;

  vec_t tbl[19];

  always #5 CLK = ~CLK;

  seq_detect_fsm #(.PATTERN_W(3), .PATTERN(3'b110), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .CLK(CLK), .RST(RST), .In1(In1), .In1_valid(In1_valid), .Clr(Clr),
    .Out1(out0), .Match_cnt(cnt0), .Sat(sat0), .State(st0));
  seq_detect_fsm #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) dut1 (
    .CLK(CLK), .RST(RST), .In1(In1), .In1_valid(In1_valid), .Clr(Clr),
    .Out1(out1), .Match_cnt(cnt1), .Sat(sat1), .State(st1));
  seq_detect_fsm #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut2 (
    .CLK(CLK), .RST(RST), .In1(In1), .In1_valid(In1_valid), .Clr(Clr),
    .Out1(out2), .Match_cnt(cnt2), .Sat(sat2), .State(st2));
  seq_detect_fsm #(.PATTERN_W(3), .PATTERN(3'b110), .OVERLAP(1'b1), .CNT_W(2)) dut3 (
    .CLK(CLK), .RST(RST), .In1(In1), .In1_valid(In1_valid), .Clr(Clr),
    .Out1(out3), .Match_cnt(cnt3), .Sat(sat3), .State(st3));

  task automatic readDut(input int i, output int st, output int o, output int c, output int s);
    case (i)
      0: begin st = int'(st0); o = int'(out0); c = int'(cnt0); s = int'(sat0); end
      1: begin st = int'(st1); o = int'(out1); c = int'(cnt1); s = int'(sat1); end
      2: begin st = int'(st2); o = int'(out2); c = int'(cnt2); s = int'(sat2); end
      default: begin st = int'(st3); o = int'(out3); c = int'(cnt3); s = int'(sat3); end
    endcase
  endtask

  // Model: remember how many bits of the current run have arrived and their value
  task automatic modelStep(input bit rst, input bit v, input bit d, input bit c);
    for (int i = 0; i < 4; i++) begin
      bit m;
      m = 1'b0;
      if (rst) begin
        mLen[i] = 0; mVal[i] = 0; mSt[i] = 0; mCnt[i] = 0; mSat[i] = 0;
      end else begin
        if (v) begin
          mLen[i] = (mLen[i] + 1 > pW[i]) ? pW[i] : mLen[i] + 1;
          mVal[i] = (mVal[i] * 2 + int'(d)) % (1 << pW[i]);
          m = (mLen[i] == pW[i]) && (mVal[i] == pPat[i]);
          if (m) mSt[i] = 2;
          else if (mLen[i] == pW[i]) mSt[i] = 1;
          else mSt[i] = 0;
          if (m && pOv[i] == 0) mLen[i] = 0;
        end else if (mSt[i] == 2) begin
          mSt[i] = (pOv[i] != 0) ? 1 : 0;
        end
        if (c) begin
          mCnt[i] = m ? 1 : 0;
          mSat[i] = (m && pMax[i] == 1) ? 1 : 0;
        end else begin
          if (m && mCnt[i] < pMax[i]) mCnt[i] = mCnt[i] + 1;
          if (mCnt[i] == pMax[i]) mSat[i] = 1;
        end
      end
    end
  endtask

  task automatic expectInst(input string name, input int i, input int est, input int eo,
                            input int ec, input int es);
    int st, o, c, s;
    readDut(i, st, o, c, s);
    vectors++;
    if (st != est || o != eo || c != ec || s != es) begin
      miscompares++;
      $display("[TB] FAIL %s inst%0d: got state=%0d out=%0d cnt=%0d sat=%0d, want state=%0d out=%0d cnt=%0d sat=%0d",
               name, i, st, o, c, s, est, eo, ec, es);
    end
  endtask

  task automatic checkOutput(input string name);
    for (int i = 0; i < 4; i++) begin
      expectInst(name, i, mSt[i], (mSt[i] == 2) ? 1 : 0, mCnt[i], mSat[i]);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit d, input bit c);
    In1_valid = v;
    In1 = d;
    Clr = c;
    @(posedge CLK);
    modelStep(RST, v, d, c);
    @(negedge CLK);
    checkOutput("model");
  endtask

  // Reset is raised between edges so its asynchronous effect is visible
  task automatic doReset();
    RST = 1'b1;
    #1;
    modelStep(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("async reset");
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset hold");
    RST = 1'b0;
    In1_valid = 1'b0;
    In1 = 1'b0;
    Clr = 1'b0;
  endtask

  initial begin
    int st1e[5] = '{0, 0, 2, 1, 2};
    int c1e[5]  = '{0, 0, 1, 1, 2};
    int st2e[5] = '{0, 0, 2, 0, 0};
    int c2e[5]  = '{0, 0, 1, 1, 1};
    bit [4:0] seq5 = 5'b10101;

    tbl[0]  = '{1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 2, 1, 1};
    tbl[7]  = '{0, 0, 0, 1, 0, 1};
    tbl[8]  = '{1, 1, 0, 1, 0, 1};
    tbl[9]  = '{1, 1, 0, 1, 0, 1};
    tbl[10] = '{1, 0, 0, 2, 1, 2};
    tbl[11] = '{1, 1, 0, 1, 0, 2};
    tbl[12] = '{1, 1, 0, 1, 0, 2};
    tbl[13] = '{1, 0, 0, 2, 1, 3};
    tbl[14] = '{1, 0, 0, 1, 0, 3};
    tbl[15] = '{0, 0, 1, 1, 0, 0};
    tbl[16] = '{1, 1, 0, 1, 0, 0};
    tbl[17] = '{1, 1, 0, 1, 0, 0};
    tbl[18] = '{1, 0, 1, 2, 1, 1};

    @(negedge CLK);
    doReset();
    expectInst("reset state", 0, 0, 0, 0, 0);

    // Basic match, valid gaps and Clr behaviour on the default instance
    for (int k = 0; k < 19; k++) begin
      applyStimulus(tbl[k].v, tbl[k].d, tbl[k].c);
      expectInst($sformatf("table[%0d]", k), 0, tbl[k].st, tbl[k].o, tbl[k].cnt, 0);
    end

    // Overlapping versus non-overlapping detection of 101
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, seq5[4-k], 1'b0);
      expectInst($sformatf("overlap bit%0d", k + 1), 1, st1e[k], (st1e[k] == 2) ? 1 : 0, c1e[k], 0);
      expectInst($sformatf("no-overlap bit%0d", k + 1), 2, st2e[k], (st2e[k] == 2) ? 1 : 0, c2e[k], 0);
    end

    // Saturation of the 2-bit counter, then Clr coincident with a match
    doReset();
    for (int m = 1; m <= 5; m++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      expectInst($sformatf("sat match%0d", m), 3, 2, 1, (m > 3) ? 3 : m, (m >= 3) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectInst("clr with match", 3, 2, 1, 1, 0);

    // Reset mid-sequence discards the partial 11 prefix
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    #2;
    doReset();
    expectInst("async reset zero", 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectInst("post-reset lone 0", 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectInst("post-reset 110", 0, 2, 1, 1, 0);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 31) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detect_fsm.md
SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

Interface
REQ-001 Parameter PATTERN_W, default 3, SHALL set the pattern length in bits; legal range 2..8.
REQ-002 Parameter PATTERN, default 3'b110, width PATTERN_W, SHALL give the target sequence; the MSB is the first bit received.
REQ-003 Parameter OVERLAP, default 1, SHALL select overlapping detection (1) or non-overlapping detection (0).
REQ-004 Parameter CNT_W, default 8, SHALL set the width of the match counter.
REQ-005 CLK  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-006 RST  input  1  SHALL be an asynchronous, active-high reset.
REQ-007 In1  input  1  SHALL carry the serial data bit.
REQ-008 In1_valid  input  1  SHALL qualify In1; a bit is accepted only on a rising edge where In1_valid=1.
REQ-009 Clr  input  1  SHALL synchronously clear Match_cnt and Sat.
REQ-010 Out1  output  1  SHALL be the registered (Moore) match flag.
REQ-011 Match_cnt  output  CNT_W  SHALL be the saturating count of matches.
REQ-012 Sat  output  1  SHALL flag that Match_cnt has saturated.
REQ-013 State  output  2  SHALL expose the current FSM state for debug.

Function
REQ-014 The FSM SHALL have three states: FILL=2'b00, SCAN=2'b01, HIT=2'b10; the encoding 2'b11 SHALL return to FILL on the next edge.
- FILL: fewer than PATTERN_W valid bits have been accepted.
- SCAN: the window is full and the last comparison missed.
- HIT: the last accepted bit completed a match.
REQ-015 Each accepted bit SHALL shift into a PATTERN_W-bit window (new bit at LSB) and increment a fill counter that saturates at PATTERN_W.
REQ-016 On an accepted bit, the FSM SHALL compute the post-shift window and fill count and move as follows.
- Window equals PATTERN and the window is full: go to HIT.
- Otherwise, window full: go to SCAN.
- Otherwise: go to FILL.
REQ-017 Out1 SHALL be 1 only in HIT, so it asserts in the cycle after the completing bit is accepted (latency 1).
REQ-018 With In1_valid=0, state, window and fill count SHALL hold, except that HIT SHALL move to SCAN (OVERLAP=1) or FILL (OVERLAP=0) after one cycle.
REQ-019 With OVERLAP=1, the window SHALL be retained after a match, and consecutive matches SHALL keep the FSM in HIT.
REQ-020 With OVERLAP=0, the fill count SHALL reset to 0 on a match, so the next match needs PATTERN_W fresh bits.
REQ-021 Match_cnt SHALL increment once on each transition into HIT, and on each HIT-to-HIT repeat.
REQ-022 Match_cnt SHALL saturate at 2^CNT_W-1; Sat SHALL set when that value is reached and stay set until Clr or RST.
REQ-023 If Clr and a match occur in the same cycle, Match_cnt SHALL become 1 and Sat SHALL become 0.
REQ-024 Clr SHALL NOT affect the state, window or fill count.

Reset
REQ-025 While RST=1, the FSM SHALL be in FILL, and Out1=0, Match_cnt=0, Sat=0, State=2'b00, with window and fill count at 0, independent of CLK.
REQ-026 Reset asserted mid-sequence SHALL discard partial progress; after release, PATTERN_W new bits SHALL be required before any match.
REQ-027 After RST deasserts, the first edge SHALL behave as normal operation from FILL.

Structure
REQ-028 The state encodings (FILL, SCAN, HIT) SHALL live in the shared package seq_pkg, alongside the PATTERN_W legal-range constants.
REQ-029 The saturating counter SHALL be a sub-module named sat_counter (parameter CNT_W; inputs inc and clr; outputs count and sat).
REQ-030 The next-state logic SHALL be purely combinational and SHALL provide a default assignment for every signal.

Verification
REQ-031 The bench SHALL cover the following directed scenarios (defaults 3/110/OVERLAP=1/CNT_W=8 unless stated).
- Basic match: accept 1,1,0 → Out1=1 for one cycle after the third bit, Match_cnt=1, State=HIT, then SCAN.
- Overlap on (PATTERN=3'b101): accept 1,0,1,0,1 → Out1 pulses after bits 3 and 5, Match_cnt=2.
- Overlap off (PATTERN=3'b101, OVERLAP=0): same stream → one pulse after bit 3, Match_cnt=1, State=FILL at the end.
- Valid gaps: 1,(idle×3),1,(idle),0 → one match; no state change during idle cycles.
- Saturation (CNT_W=2): five matches → Match_cnt=3, Sat=1; Clr coincident with a sixth match → Match_cnt=1, Sat=0.
- Reset mid-sequence: accept 1,1, assert RST asynchronously between edges → outputs zero immediately; after release, the input 0 alone does not match, and 1,1,0 does.
